alu_operand_loader: RTL and testbench
=====================================

# alu_operand_loader

Sequential front end that drives the combinational 8-bit ALU on the Basys3 board. Captures operand 1, operand 2 and opcode from the slide switches on successive presses of a single load button, presents them as stable registered outputs to the ALU, then captures the ALU result into a display register. Sits between the board pins (switches, buttons) and the ALU/LED logic in the top level.

## Interface
- NB_DATA, 8, operand and result width
- NB_OPCODE, 6, opcode width (taken from i_sw[NB_OPCODE-1:0])
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level change is accepted (only with debounce compiled in)

- i_clk  input  1  system clock; all logic on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_sw  input  NB_DATA  raw slide switch data
- i_btn_load  input  1  raw load push-button, asynchronous to i_clk
- i_btn_clear  input  1  raw clear push-button, asynchronous to i_clk
- i_result  input  NB_DATA  ALU result (combinational from o_op_1/o_op_2/o_opcode)
- o_op_1  output  NB_DATA  registered operand 1 to ALU
- o_op_2  output  NB_DATA  registered operand 2 to ALU
- o_opcode  output  NB_OPCODE  registered opcode to ALU
- o_result  output  NB_DATA  captured ALU result for LEDs
- o_done  output  1  one-cycle pulse when o_result is updated
- o_state  output  3  current FSM state encoding (LED indicator)

## Operation
- Both buttons pass through a 2-flop synchronizer. Load path additionally debounced (see Configuration), then rising-edge detected into a one-cycle load event. Clear is synchronized level only, no debounce.
- FSM states / encoding: S_OP1=0, S_OP2=1, S_OPC=2, S_EXEC=3, S_SHOW=4. Encodings 5-7 illegal -> next state S_OP1.
- S_OP1: load event -> o_op_1 <= i_sw, go S_OP2.
- S_OP2: load event -> o_op_2 <= i_sw, go S_OPC.
- S_OPC: load event -> o_opcode <= i_sw[NB_OPCODE-1:0], go S_EXEC.
- S_EXEC: unconditional, one cycle. o_result <= i_result, o_done = 1 for this cycle's edge, go S_SHOW.
- S_SHOW: holds result. Load event -> o_op_1 <= i_sw, go S_OP2 (new sequence starts directly).
- Load events arriving in S_EXEC are dropped (no queuing).
- Synchronized clear high: state <= S_OP1; o_op_1, o_op_2, o_opcode, o_result <= 0. Clear has priority over a simultaneous load event.
- Operand/opcode outputs change only on their own load; held stable otherwise, so the ALU sees static inputs while the operator sets switches. Invalid opcodes are passed through unchanged (ALU outputs 0).
- No arithmetic in this block; widths pass through unmodified.

## Timing
- Reset (i_rst_n low at a rising edge): state S_OP1; o_op_1=0, o_op_2=0, o_opcode=0, o_result=0, o_done=0, o_state=0; synchronizer, debounce counter and edge-detect flops cleared to 0. Reset mid-sequence discards partial operands.
- Without debounce: raw button high first sampled at edge E0 -> synchronizer output high after E1 -> load event high during cycle after E1 -> target register updates at E2.
- With debounce: add DEBOUNCE_CYCLES edges between synchronizer output change and debounced level change; release is debounced identically.
- o_result updates and o_done pulses at the edge one cycle after the opcode load (S_EXEC); o_done deasserts at the next edge.
- Clear: same 2-edge synchronizer latency; effect at the edge after synchronized level goes high, held while high.
- Holding load button produces exactly one event; a new event requires release (debounced low) then press.

## Configuration
- LOADER_DEBOUNCE_EN defined: load path includes a counter of width $clog2(DEBOUNCE_CYCLES+1); counter resets whenever synchronized input equals debounced level, debounced level flips when counter reaches DEBOUNCE_CYCLES.
- Not defined: debounced level = synchronized level directly; DEBOUNCE_CYCLES unused; no counter synthesized.

## Test plan
- Reset: hold i_rst_n low 2 cycles with i_sw=8'hFF, buttons high -> all outputs 0, o_state=0 after release.
- Full sequence (debounce off): press load with i_sw=8'h05, 8'h03, 8'h20 (ADD), i_result tied to ALU -> o_op_1=5, o_op_2=3, o_opcode=6'h20, o_result=8'h08 with single o_done pulse, o_state=4.
- Button timing: raw press sampled at E0 -> o_op_1 updates at E2; button held 50 cycles -> only one load, o_state advances by 1.
- Debounce on, DEBOUNCE_CYCLES=4: 3-cycle glitch on i_btn_load -> no state change; 10-cycle press -> one load, register update DEBOUNCE_CYCLES edges later than debounce-off case.
- Clear priority: in S_OPC with o_op_1=8'h7F, assert clear and load simultaneously -> state S_OP1, all operand/result outputs 0, no load applied.
- Restart from S_SHOW: load with i_sw=8'hF0 -> o_op_1=8'hF0, state S_OP2, o_result retains previous value until next S_EXEC.

Source files
------------

// File: rtl/alu_operand_loader.sv
// Button-driven loader: op1/op2/opcode from switches, then captures the ALU result (`LOADER_DEBOUNCE_EN adds load debounce).
// Latency: raw load press to register update is 2 edges (+DEBOUNCE_CYCLES when debounced); result lands one edge after opcode.
// Backpressure: none; load events arriving in S_EXEC are dropped, clear overrides everything while held.
module alu_operand_loader #(
    parameter int NB_DATA         = 8,
    parameter int NB_OPCODE       = 6,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NB_DATA-1:0]   i_sw,
    input  logic                 i_btn_load,
    input  logic                 i_btn_clear,
    input  logic [NB_DATA-1:0]   i_result,
    output logic [NB_DATA-1:0]   o_op_1,
    output logic [NB_DATA-1:0]   o_op_2,
    output logic [NB_OPCODE-1:0] o_opcode,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_done,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        S_OP1  = 3'd0,
        S_OP2  = 3'd1,
        S_OPC  = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    state_t               state_q,  state_d;
    logic [NB_DATA-1:0]   op1_q,    op1_d;
    logic [NB_DATA-1:0]   op2_q,    op2_d;
    logic [NB_OPCODE-1:0] opc_q,    opc_d;
    logic [NB_DATA-1:0]   result_q, result_d;
    logic                 done_q,   done_d;

    logic ld_meta_q, ld_sync_q;
    logic clr_meta_q, clr_sync_q;
    logic ld_deb;
    logic ld_prev_q;
    logic ld_evt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ld_meta_q  <= 1'b0;
            ld_sync_q  <= 1'b0;
            clr_meta_q <= 1'b0;
            clr_sync_q <= 1'b0;
        end else begin
            ld_meta_q  <= i_btn_load;
            ld_sync_q  <= ld_meta_q;
            clr_meta_q <= i_btn_clear;
            clr_sync_q <= clr_meta_q;
        end
    end

`ifdef LOADER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             ld_deb_q,  ld_deb_d;

    // Level flips on the edge where the count of disagreeing samples reaches DEBOUNCE_CYCLES.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        ld_deb_d  = ld_deb_q;
        if (ld_sync_q == ld_deb_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == CNT_LAST) begin
            deb_cnt_d = '0;
            ld_deb_d  = ld_sync_q;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            deb_cnt_q <= '0;
            ld_deb_q  <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            ld_deb_q  <= ld_deb_d;
        end
    end

    assign ld_deb = ld_deb_q;
`else
    assign ld_deb = ld_sync_q;
`endif

    assign ld_evt = ld_deb & ~ld_prev_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ld_prev_q <= 1'b0;
        end else begin
            ld_prev_q <= ld_deb;
        end
    end

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        opc_d    = opc_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (clr_sync_q) begin
            state_d  = S_OP1;
            op1_d    = '0;
            op2_d    = '0;
            opc_d    = '0;
            result_d = '0;
        end else begin
            case (state_q)
                S_OP1: begin
                    if (ld_evt) begin
                        op1_d   = i_sw;
                        state_d = S_OP2;
                    end
                end
                S_OP2: begin
                    if (ld_evt) begin
                        op2_d   = i_sw;
                        state_d = S_OPC;
                    end
                end
                S_OPC: begin
                    if (ld_evt) begin
                        opc_d   = i_sw[NB_OPCODE-1:0];
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // ALU inputs have been stable for a full cycle here.
                    result_d = i_result;
                    done_d   = 1'b1;
                    state_d  = S_SHOW;
                end
                S_SHOW: begin
                    if (ld_evt) begin
                        op1_d   = i_sw;
                        state_d = S_OP2;
                    end
                end
                default: begin
                    state_d = S_OP1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_OP1;
            op1_q    <= '0;
            op2_q    <= '0;
            opc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            opc_q    <= opc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign o_op_1   = op1_q;
    assign o_op_2   = op2_q;
    assign o_opcode = opc_q;
    assign o_result = result_q;
    assign o_done   = done_q;
    assign o_state  = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomized bench for alu_operand_loader with a per-cycle behavioural model plus directed literal checks.
module tb_alu_operand_loader;

`ifdef LOADER_DEBOUNCE_EN
    localparam int DEB = 4;
`else
    localparam int DEB = 0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_sw;
    logic       i_btn_load;
    logic       i_btn_clear;
    logic [7:0] i_result;
    logic [7:0] o_op_1, o_op_2, o_result;
    logic [5:0] o_opcode;
    logic       o_done;
    logic [2:0] o_state;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    bit started     = 0;

    always #5 i_clk = ~i_clk;

    alu_operand_loader #(
        .NB_DATA(8),
        .NB_OPCODE(6),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_sw(i_sw),
        .i_btn_load(i_btn_load),
        .i_btn_clear(i_btn_clear),
        .i_result(i_result),
        .o_op_1(o_op_1),
        .o_op_2(o_op_2),
        .o_opcode(o_opcode),
        .o_result(o_result),
        .o_done(o_done),
        .o_state(o_state)
    );

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   alu = a + b;
            6'h22:   alu = a - b;
            6'h24:   alu = a & b;
            6'h25:   alu = a | b;
            6'h26:   alu = a ^ b;
            default: alu = 8'h00;
        endcase
    endfunction

    assign i_result = alu(o_op_1, o_op_2, o_opcode);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: button samples are kept as a short history; sync output is the raw sample two edges back.
    int         m_state;
    logic [7:0] m_op1, m_op2, m_res;
    logic [5:0] m_opc;
    bit         m_done;
    bit         ld_h0, ld_h1, clr_h0, clr_h1;
    bit         deb, deb_last;
    int         stable;

    always @(posedge i_clk) begin
        started = 1;
        if (!i_rst_n) begin
            m_state = 0; m_op1 = 0; m_op2 = 0; m_opc = 0; m_res = 0; m_done = 0;
            ld_h0 = 0; ld_h1 = 0; clr_h0 = 0; clr_h1 = 0;
            deb = 0; deb_last = 0; stable = 0;
        end else begin : step
            bit s_ld, clr, evt, deb_now;
            s_ld    = ld_h1;
            clr     = clr_h1;
            deb_now = (DEB == 0) ? s_ld : deb;
            evt     = deb_now && !deb_last;
            deb_last = deb_now;
            if (DEB > 0) begin
                if (s_ld != deb) begin
                    stable++;
                    if (stable == DEB) begin
                        deb = s_ld;
                        stable = 0;
                    end
                end else begin
                    stable = 0;
                end
            end
            m_done = 0;
            if (clr) begin
                m_state = 0; m_op1 = 0; m_op2 = 0; m_opc = 0; m_res = 0;
            end else begin
                case (m_state)
                    0: if (evt) begin m_op1 = i_sw; m_state = 1; end
                    1: if (evt) begin m_op2 = i_sw; m_state = 2; end
                    2: if (evt) begin m_opc = i_sw[5:0]; m_state = 3; end
                    3: begin m_res = alu(m_op1, m_op2, m_opc); m_done = 1; m_state = 4; end
                    default: if (evt) begin m_op1 = i_sw; m_state = 1; end
                endcase
            end
            ld_h1 = ld_h0; ld_h0 = i_btn_load;
            clr_h1 = clr_h0; clr_h0 = i_btn_clear;
        end
    end

    always @(negedge i_clk) begin
        if (started) begin
            chk("model_op1", o_op_1, m_op1);
            chk("model_op2", o_op_2, m_op2);
            chk("model_opcode", o_opcode, m_opc);
            chk("model_result", o_result, m_res);
            chk("model_done", o_done, m_done);
            chk("model_state", o_state, m_state);
            if (o_done === 1'b1) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic press(input logic [7:0] sw, input int hold);
        i_sw = sw;
        i_btn_load = 1'b1;
        tick(hold);
        i_btn_load = 1'b0;
        tick(DEB + 4);
    endtask

    task automatic rand_sw();
        i_sw = 8'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 4))
                0: i_sw[5:0] = 6'h20;
                1: i_sw[5:0] = 6'h22;
                2: i_sw[5:0] = 6'h24;
                3: i_sw[5:0] = 6'h25;
                default: i_sw[5:0] = 6'h26;
            endcase
        end
    endtask

    initial begin
        int d0;
        i_rst_n = 1'b0; i_sw = 8'hFF; i_btn_load = 1'b1; i_btn_clear = 1'b1;
        tick(2);
        chk("reset_state", o_state, 0);
        chk("reset_op1", o_op_1, 0);
        chk("reset_result", o_result, 0);
        chk("reset_done", o_done, 0);
        i_rst_n = 1'b1; i_btn_load = 1'b0; i_btn_clear = 1'b0; i_sw = 8'h00;
        tick(3);

        d0 = done_cnt;
        press(8'h05, DEB + 3);
        press(8'h03, DEB + 3);
        press(8'h20, DEB + 3);
        chk("seq_op1", o_op_1, 8'h05);
        chk("seq_op2", o_op_2, 8'h03);
        chk("seq_opcode", o_opcode, 6'h20);
        chk("seq_result", o_result, 8'h08);
        chk("seq_state", o_state, 4);
        chk("seq_done_pulses", done_cnt - d0, 1);

        // Press from S_SHOW, held 50 cycles: one load, landing DEB+2 edges after first sample.
        i_sw = 8'hF0; i_btn_load = 1'b1;
        tick(DEB + 2);
        chk("timing_before", o_op_1, 8'h05);
        tick(1);
        chk("timing_after", o_op_1, 8'hF0);
        chk("restart_state", o_state, 1);
        chk("restart_result_kept", o_result, 8'h08);
        tick(50 - DEB - 3);
        i_btn_load = 1'b0;
        tick(DEB + 4);
        chk("held_state", o_state, 1);
        chk("held_op2", o_op_2, 8'h03);

        press(8'h10, DEB + 3);
        press(8'h22, DEB + 3);
        chk("sub_result", o_result, 8'hE0);
        chk("sub_state", o_state, 4);

        press(8'h7F, DEB + 3);
        press(8'h01, DEB + 3);
        chk("pre_clear_state", o_state, 2);
        chk("pre_clear_op1", o_op_1, 8'h7F);
        i_sw = 8'h25; i_btn_load = 1'b1; i_btn_clear = 1'b1;
        tick(DEB + 6);
        i_btn_load = 1'b0; i_btn_clear = 1'b0;
        tick(DEB + 4);
        chk("clear_state", o_state, 0);
        chk("clear_op1", o_op_1, 0);
        chk("clear_op2", o_op_2, 0);
        chk("clear_opcode", o_opcode, 0);
        chk("clear_result", o_result, 0);

`ifdef LOADER_DEBOUNCE_EN
        i_sw = 8'h5A; i_btn_load = 1'b1;
        tick(3);
        i_btn_load = 1'b0;
        tick(DEB + 4);
        chk("glitch_state", o_state, 0);
        chk("glitch_op1", o_op_1, 0);
`endif

        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            rand_sw();
            if (r < 3) begin
                i_rst_n = 1'b0;
                tick($urandom_range(1, 2));
                i_rst_n = 1'b1;
            end else if (r < 8) begin
                i_btn_clear = 1'b1;
                if ($urandom_range(0, 1) == 1) i_btn_load = 1'b1;
                tick($urandom_range(1, 4));
                i_btn_clear = 1'b0;
                i_btn_load = 1'b0;
                tick($urandom_range(1, 3));
            end else begin
                i_btn_load = 1'b1;
                for (int h = $urandom_range(1, DEB + 4); h > 0; h--) begin
                    tick(1);
                    if ($urandom_range(0, 3) == 0) rand_sw();
                end
                i_btn_load = 1'b0;
                for (int g = $urandom_range(1, DEB + 5); g > 0; g--) begin
                    tick(1);
                    rand_sw();
                end
            end
        end
        tick(DEB + 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
